// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl: programmable timer built around a WIDTH-bit up-counter.
// A prescaler divides the clock and a compare period marks each expiry. The
// timer runs one-shot or periodic and accepts clear/pause/start strobes. Each
// expiry produces a single-cycle registered tick.
module counter_timer_ctrl #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e                state_q,    state_d;
    logic [WIDTH-1:0]      count_q,    count_d;
    logic [PRESCALE_W-1:0] presc_q,    presc_d;
    logic                  tick_q,     tick_d;
    logic                  mode_q,     mode_d;
    logic [WIDTH-1:0]      period_q,   period_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    // Next-state and datapath decisions; clear wins over pause, and pause over start.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        mode_d     = mode_q;
        period_d   = period_q;
        prescale_d = prescale_q;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
            presc_d = {PRESCALE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Configuration is captured only here, never on resume.
                        state_d    = ST_RUN;
                        mode_d     = mode;
                        period_d   = period;
                        prescale_d = prescale;
                        count_d    = {WIDTH{1'b0}};
                        presc_d    = {PRESCALE_W{1'b0}};
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // Freeze without advancing, so no tick on this edge.
                        state_d = ST_PAUSED;
                    end else if (presc_q == prescale_q) begin
                        presc_d = {PRESCALE_W{1'b0}};
                        if (count_q == period_q) begin
                            // Compare before increment keeps all-ones periods from wrapping.
                            tick_d = 1'b1;
                            if (mode_q) begin
                                count_d = {WIDTH{1'b0}};
                            end else begin
                                count_d = period_q;
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        presc_d = presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = {WIDTH{1'b0}};
                    presc_d = {PRESCALE_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= {WIDTH{1'b0}};
            presc_q    <= {PRESCALE_W{1'b0}};
            tick_q     <= 1'b0;
            mode_q     <= 1'b0;
            period_q   <= {WIDTH{1'b0}};
            prescale_q <= {PRESCALE_W{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign state = state_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed testbench for counter_timer_ctrl with hand-computed expectations.
module tb_counter_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pause;
    logic        clear;
    logic        mode;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] count;
    logic        tick;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    counter_timer_ctrl #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .count    (count),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start strobe; returns at the negedge right after the start edge.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        mode = 1'b0; period = 16'd0; prescale = 8'd0;
        step(2);
        rst = 1'b0;
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_tick",  32'(tick),  32'd0);

        // Reset in the middle of a run.
        mode = 1'b1; period = 16'd20; prescale = 8'd0;
        pulse_start();
        step(7);
        check_val("mid_count", 32'(count), 32'd7);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_val("mrst_state", 32'(state), 32'd0);
        check_val("mrst_count", 32'(count), 32'd0);
        check_val("mrst_tick",  32'(tick),  32'd0);
        check_val("mrst_busy",  32'(busy),  32'd0);

        // Periodic, period 3, prescale 0: tick every 4 cycles.
        mode = 1'b1; period = 16'd3; prescale = 8'd0;
        pulse_start();
        check_val("per_c0", 32'(count), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check_val("per_count", 32'(count), 32'(k % 4));
            check_val("per_tick",  32'(tick),  32'((k % 4) == 0));
            check_val("per_busy",  32'(busy),  32'd1);
        end

        // One-shot, period 5, prescale 1: single tick 12 cycles after start.
        pulse_clear();
        mode = 1'b0; period = 16'd5; prescale = 8'd1;
        pulse_start();
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check_val("os_count", 32'(count), (k >= 12) ? 32'd5 : 32'(k / 2));
            check_val("os_tick",  32'(tick),  32'(k == 12));
            check_val("os_state", 32'(state), (k >= 12) ? 32'd3 : 32'd1);
            check_val("os_done",  32'(done),  32'(k >= 12));
        end

        // Pause at count 4, change period while paused, resume with the old one.
        pulse_clear();
        mode = 1'b1; period = 16'd9; prescale = 8'd0;
        pulse_start();
        step(4);
        check_val("pz_pre", 32'(count), 32'd4);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        check_val("pz_state", 32'(state), 32'd2);
        check_val("pz_tick0", 32'(tick),  32'd0);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check_val("pz_hold", 32'(count), 32'd4);
            check_val("pz_tick", 32'(tick),  32'd0);
        end
        period = 16'd2;
        pulse_start();
        check_val("rs_state", 32'(state), 32'd1);
        check_val("rs_count", 32'(count), 32'd4);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check_val("rs_cnt",  32'(count), 32'((4 + k) % 10));
            check_val("rs_tick", 32'(tick),  32'(k == 6));
        end

        // All three strobes at count 6: clear wins.
        step(6);
        check_val("sim_pre", 32'(count), 32'd6);
        clear = 1'b1; pause = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; pause = 1'b0; start = 1'b0;
        check_val("sim_state", 32'(state), 32'd0);
        check_val("sim_count", 32'(count), 32'd0);

        // Start while running is ignored.
        period = 16'd9; mode = 1'b1;
        pulse_start();
        step(3);
        pulse_start();
        check_val("rsta_count", 32'(count), 32'd4);
        check_val("rsta_state", 32'(state), 32'd1);

        // Start from DONE with a new period restarts.
        pulse_clear();
        mode = 1'b0; period = 16'd2;
        pulse_start();
        step(3);
        check_val("dn_state", 32'(state), 32'd3);
        check_val("dn_count", 32'(count), 32'd2);
        mode = 1'b1; period = 16'd1;
        pulse_start();
        check_val("dr_state", 32'(state), 32'd1);
        check_val("dr_count", 32'(count), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_val("dr_cnt",  32'(count), 32'(k % 2));
            check_val("dr_tick", 32'(tick),  32'((k % 2) == 0));
        end

        // Period 0, prescale 0: tick every cycle, count stays 0.
        pulse_clear();
        mode = 1'b1; period = 16'd0; prescale = 8'd0;
        pulse_start();
        check_val("z_tick0", 32'(tick), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_val("z_tick",  32'(tick),  32'd1);
            check_val("z_count", 32'(count), 32'd0);
        end

        // Period all ones: tick 65536 cycles after start, count wraps cleanly.
        pulse_clear();
        check_val("clr_tick", 32'(tick), 32'd0);
        period = 16'hFFFF; prescale = 8'd0; mode = 1'b1;
        pulse_start();
        step(65535);
        check_val("max_cnt",   32'(count), 32'h0000FFFF);
        check_val("max_tick0", 32'(tick),  32'd0);
        step(1);
        check_val("max_wrap",  32'(count), 32'd0);
        check_val("max_tick",  32'(tick),  32'd1);
        step(1);
        check_val("max_next",  32'(count), 32'd1);
        check_val("max_tick1", 32'(tick),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
